fetch_queue: RTL

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline buffer. It owns the program counter and drives the combinational instruction-memory address. It captures fetched words into a small prefetch FIFO and presents the head entry, as {instruction, PC+4}, to the IF/ID buffer. It absorbs decode stalls without losing fetched words and flushes on a taken branch redirect from the MEM stage.

---
 rtl/fetch_queue_if.sv | 42 ++++
 rtl/fetch_queue.sv | 106 ++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Handshake/bus bundle between the fetch front end and its neighbours (imem, decode, MEM redirect).
// FETCH_QUEUE_PERF_EN adds the three performance counter outputs.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_stall;
  logic          i_branch_taken;
  logic [31:0]   i_branch_address;
  logic [31:0]   o_imem_address;
  logic [31:0]   i_imem_data;
  logic [31:0]   o_instruction;
  logic [31:0]   o_address_pc;
  logic          o_valid;
  logic [CW-1:0] o_count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]   o_flush_count;
  logic [31:0]   o_stall_count;
  logic [31:0]   o_empty_count;

  modport master (
    output i_stall, i_branch_taken, i_branch_address, i_imem_data,
    input  o_imem_address, o_instruction, o_address_pc, o_valid, o_count,
           o_flush_count, o_stall_count, o_empty_count
  );
  modport slave (
    input  i_stall, i_branch_taken, i_branch_address, i_imem_data,
    output o_imem_address, o_instruction, o_address_pc, o_valid, o_count,
           o_flush_count, o_stall_count, o_empty_count
  );
`else
  modport master (
    output i_stall, i_branch_taken, i_branch_address, i_imem_data,
    input  o_imem_address, o_instruction, o_address_pc, o_valid, o_count
  );
  modport slave (
    input  i_stall, i_branch_taken, i_branch_address, i_imem_data,
    output o_imem_address, o_instruction, o_address_pc, o_valid, o_count
  );
`endif
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, prefetches into a small FIFO, flushes on branch redirect.
// Optional performance counters are enabled with FETCH_QUEUE_PERF_EN.
//
// state    | meaning
// RUN      | normal fetch; push when FIFO has room or head is consumed
// REDIRECT | first cycle after a flush; FIFO known empty, target word is fetched
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave bus
);
  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0]   STEP = 32'(PC_STEP);

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pcn_mem [DEPTH];
  logic          valid;
  logic          flush;
  logic          pop;
  logic          push;

  assign valid = (count != '0);
  assign flush = bus.i_branch_taken;
  assign pop   = valid & ~bus.i_stall & ~flush;
  assign push  = ~flush & ((state == REDIRECT) | (count < FULL) | pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      state <= REDIRECT;
      pc    <= bus.i_branch_address;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= RUN;
      if (pop)
        head <= head + PW'(1);
      if (push) begin
        tail <= tail + PW'(1);
        pc   <= pc + STEP;
      end
      if (push & ~pop)
        count <= count + CW'(1);
      else if (pop & ~push)
        count <= count - CW'(1);
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= bus.i_imem_data;
      pcn_mem[tail]   <= pc + STEP;
    end
  end

  assign bus.o_imem_address = pc;
  assign bus.o_valid        = valid;
  assign bus.o_count        = count;
  assign bus.o_instruction  = valid ? instr_mem[head] : 32'h0000_0000;
  assign bus.o_address_pc   = valid ? pcn_mem[head] : 32'h0000_0000;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] flush_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] empty_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
      empty_cnt <= '0;
    end else begin
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
      if (valid && bus.i_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (!valid && empty_cnt != '1)
        empty_cnt <= empty_cnt + 32'd1;
    end
  end

  assign bus.o_flush_count = flush_cnt;
  assign bus.o_stall_count = stall_cnt;
  assign bus.o_empty_count = empty_cnt;
`endif
endmodule
